dividend_from_quotient_16_4: RTL

Sequential shift-add unit that inverts the quotient-by-divisor loop. It reconstructs dividend = quotient*divisor + remainder from a 16-bit quotient, 4-bit divisor and 4-bit remainder. It uses the same level-sampled start / result_ready handshake and four-state loop controller as the integer-division blocks. It sits beside the divider in the intdec test projects, for round-trip checking and for software-visible multiply-add.

---
 rtl/intloop_defs.sv | 12 +
 rtl/dividend_from_quotient_16_4_if.sv | 25 ++
 rtl/dividend_from_quotient_16_4.sv | 116 +++++++++++
 3 files changed

// File: rtl/intloop_defs.sv
// Loop-controller state encodings shared by the integer divide / multiply-add blocks.
// The divider blocks rely on these exact values, so keep them fixed.
package intloop_defs;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        INITS     = 2'd1,
        WAITING   = 2'd2,
        RESTARTED = 2'd3
    } loop_state_t;

endpackage

// File: rtl/dividend_from_quotient_16_4_if.sv
// Operand / result bundle for dividend_from_quotient_16_4.
// The master drives start and the operands; the slave (the unit) returns the result.
interface dividend_from_quotient_16_4_if #(
    parameter int W  = 16,
    parameter int DW = 4
);
    logic          start;
    logic [W-1:0]  quotient;
    logic [DW-1:0] divisor;
    logic [DW-1:0] remainder;
    logic [W-1:0]  result;
    logic          overflow;
    logic          result_ready;
    logic          rem_err;

    modport master (
        output start, quotient, divisor, remainder,
        input  result, overflow, result_ready, rem_err
    );

    modport slave (
        input  start, quotient, divisor, remainder,
        output result, overflow, result_ready, rem_err
    );
endinterface

// File: rtl/dividend_from_quotient_16_4.sv
// Shift-add reconstruction of dividend = quotient*divisor + remainder.
// Optional remainder range check is enabled by defining DIVTRIPLE_REMCHECK_EN.
module dividend_from_quotient_16_4
    import intloop_defs::*;
#(
    parameter int W  = 16,
    parameter int DW = 4
) (
    input logic clk,
    input logic rst,
    dividend_from_quotient_16_4_if.slave bus
);

    localparam int AW = W + DW;
    localparam int IW = $clog2(DW + 1);

    loop_state_t   state, state_next;
    logic [AW-1:0] acc, acc_next;
    logic [AW-1:0] mcand, mcand_next;
    logic [DW-1:0] mbits, mbits_next;
    logic [IW-1:0] iter, iter_next;
    logic [W-1:0]  result_q, result_next;
    logic          overflow_q, overflow_next;
`ifdef DIVTRIPLE_REMCHECK_EN
    logic          rem_err_q, rem_err_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= READY;
            acc        <= '0;
            mcand      <= '0;
            mbits      <= '0;
            iter       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
`ifdef DIVTRIPLE_REMCHECK_EN
            rem_err_q  <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            mcand      <= mcand_next;
            mbits      <= mbits_next;
            iter       <= iter_next;
            result_q   <= result_next;
            overflow_q <= overflow_next;
`ifdef DIVTRIPLE_REMCHECK_EN
            rem_err_q  <= rem_err_next;
`endif
        end
    end

    // start overrides everything and abandons a busy loop without touching the published result.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        mcand_next    = mcand;
        mbits_next    = mbits;
        iter_next     = iter;
        result_next   = result_q;
        overflow_next = overflow_q;
`ifdef DIVTRIPLE_REMCHECK_EN
        rem_err_next  = rem_err_q;
`endif
        if (bus.start) begin
            state_next = INITS;
        end else begin
            case (state)
                READY: begin
                    state_next = READY;
                end
                INITS: begin
                    acc_next   = {{W{1'b0}}, bus.remainder};
                    mcand_next = {{DW{1'b0}}, bus.quotient};
                    mbits_next = bus.divisor;
                    iter_next  = IW'(DW);
`ifdef DIVTRIPLE_REMCHECK_EN
                    rem_err_next = (bus.remainder >= bus.divisor);
`endif
                    state_next = RESTARTED;
                end
                RESTARTED: begin
                    state_next = WAITING;
                end
                WAITING: begin
                    // The accumulator is wide enough that the add never wraps.
                    if (iter == '0 || mbits == '0) begin
                        result_next   = acc[W-1:0];
                        overflow_next = |acc[AW-1:W];
                        state_next    = READY;
                    end else begin
                        acc_next   = acc + (mbits[0] ? mcand : '0);
                        mcand_next = mcand << 1;
                        mbits_next = mbits >> 1;
                        iter_next  = iter - IW'(1);
                        state_next = RESTARTED;
                    end
                end
                default: begin
                    state_next = READY;
                end
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.overflow     = overflow_q;
    assign bus.result_ready = (state == READY) && !bus.start;
`ifdef DIVTRIPLE_REMCHECK_EN
    assign bus.rem_err      = rem_err_q;
`else
    assign bus.rem_err      = 1'b0;
`endif

endmodule
